dpi_stream_feeder: RTL and testbench

DPI_STREAM_FEEDER -- requirements
Module: dpi_stream_feeder

---
 rtl/dpi_pkg.sv | 36 +++
 rtl/dpi_stream_table.sv | 97 +++++++++
 rtl/dpi_stream_feeder.sv | 183 ++++++++++++++++++
 tb/tb_dpi_stream_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_pkg.sv
// Shared definitions for the stream feeder and its stream table.
//   STREAM_ID_W / NUM_STREAMS : stream table geometry (64 entries, 6-bit id)
//   KEY_W_MAX                 : widest flow key a table entry can hold
//   COOLDOWN                  : IDLE cycles after HOLD before a new sop is taken
//   state_t                   : feeder FSM states
//   stream_entry_t            : one stream table entry (valid + key)
package dpi_pkg;

  localparam int STREAM_ID_W = 6;
  localparam int NUM_STREAMS = 64;
  localparam int KEY_W_MAX   = 64;

  // Two IDLE cycles after HOLD, together with LOOKUP, keep at least four
  // quiet cycles between an eop and the next load_state.
  localparam logic [1:0] COOLDOWN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_EOP,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [KEY_W_MAX-1:0] key;
  } stream_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// 64-entry flow-key CAM with allocate / round-robin evict and the per-stream
// regex enable table.
//   i_lookup          : one-cycle strobe; allocates an entry on a miss
//   i_key             : key to look up (held stable while i_lookup is high)
//   i_cfg_*           : enable-mask write port
//   o_sel_id / o_new  : combinational lookup result for i_key
//   o_sel_enable      : enable_table entry for o_sel_id
//   o_streams_active  : number of valid entries
//   o_evict_cnt       : saturating count of evictions
module dpi_stream_table
  import dpi_pkg::*;
#(
  parameter int NUM_RE = 8,
  parameter int KEY_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_lookup,
  input  logic [KEY_W-1:0]       i_key,
  input  logic                   i_cfg_we,
  input  logic [5:0]             i_cfg_addr,
  input  logic [NUM_RE-1:0]      i_cfg_enable,
  output logic [STREAM_ID_W-1:0] o_sel_id,
  output logic                   o_new,
  output logic [NUM_RE-1:0]      o_sel_enable,
  output logic [6:0]             o_streams_active,
  output logic [15:0]            o_evict_cnt
);

  stream_entry_t          r_tab    [NUM_STREAMS];
  logic [NUM_RE-1:0]      r_en_tab [NUM_STREAMS];
  logic [STREAM_ID_W-1:0] r_victim;
  logic [6:0]             r_streams_active;
  logic [15:0]            r_evict_cnt;

  logic [KEY_W_MAX-1:0]   w_key_ext;
  logic                   w_hit;
  logic                   w_free;
  logic [STREAM_ID_W-1:0] w_hit_idx;
  logic [STREAM_ID_W-1:0] w_free_idx;

  assign w_key_ext = KEY_W_MAX'(i_key);

  // Scanning downwards leaves the lowest matching / free index in place.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (r_tab[i].valid && (r_tab[i].key == w_key_ext)) begin
        w_hit     = 1'b1;
        w_hit_idx = STREAM_ID_W'(i);
      end
      if (!r_tab[i].valid) begin
        w_free     = 1'b1;
        w_free_idx = STREAM_ID_W'(i);
      end
    end
  end

  assign o_sel_id         = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_victim);
  assign o_new            = ~w_hit;
  assign o_sel_enable     = r_en_tab[o_sel_id];
  assign o_streams_active = r_streams_active;
  assign o_evict_cnt      = r_evict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        r_tab[i] <= '0;
      end
      r_victim         <= '0;
      r_streams_active <= '0;
      r_evict_cnt      <= '0;
    end else if (i_lookup && !w_hit) begin
      r_tab[o_sel_id] <= {1'b1, w_key_ext};
      if (w_free) begin
        r_streams_active <= r_streams_active + 7'd1;
      end else begin
        r_evict_cnt <= sat_inc16(r_evict_cnt);
        r_victim    <= r_victim + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        r_en_tab[i] <= '1;
      end
    end else if (i_cfg_we) begin
      r_en_tab[i_cfg_addr] <= i_cfg_enable;
    end
  end

endmodule

// File: rtl/dpi_stream_feeder.sv
// Packet-to-regex-wrapper feeder: looks up the flow of each packet, issues a
// state-restore command, streams the bytes and commits with eop.
//   clk, rst                    : clock, async active-high reset
//   s_data/s_valid/s_sop/s_eop  : input packet byte stream, s_ready back
//   s_key                       : flow key, valid on the sop beat
//   cfg_we/cfg_addr/cfg_enable  : per-stream regex enable write port
//   char_in/char_in_vld         : byte to the wrappers
//   load_state/new_stream_id/stream_id : state-restore command
//   eop/enable                  : end-of-packet commit, per-regex enable
//   streams_active/evict_cnt/drop_cnt  : status
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | wait for a sop beat (after the cooldown); drop stray beats
// ST_LOOKUP | CAM search, allocate/evict on a miss
// ST_LOAD   | load_state pulse with stream_id / new_stream_id
// ST_GAP    | quiet cycle while the wrappers restore state
// ST_STREAM | forward accepted beats until the eop beat
// ST_EOP    | last byte on char_in, no new beats
// ST_HOLD   | eop pulse, stream_id held for the state write-back
module dpi_stream_feeder
  import dpi_pkg::*;
#(
  parameter int NUM_RE = 8,
  parameter int KEY_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  input  logic [KEY_W-1:0]       s_key,
  output logic                   s_ready,
  input  logic                   cfg_we,
  input  logic [5:0]             cfg_addr,
  input  logic [NUM_RE-1:0]      cfg_enable,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   eop,
  output logic [NUM_RE-1:0]      enable,
  output logic [6:0]             streams_active,
  output logic [15:0]            evict_cnt,
  output logic [15:0]            drop_cnt
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [KEY_W-1:0]       r_key;
  logic [STREAM_ID_W-1:0] r_stream_id;
  logic                   r_new;
  logic [NUM_RE-1:0]      r_enable;
  logic [7:0]             r_char;
  logic                   r_char_vld;
  logic                   r_eop;
  logic                   r_sop_taken;
  logic [1:0]             r_cool;
  logic [15:0]            r_drop_cnt;

  logic [STREAM_ID_W-1:0] w_sel_id;
  logic                   w_new;
  logic [NUM_RE-1:0]      w_sel_enable;
  logic                   w_lookup;
  logic                   w_load_key;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_s_ready;

  dpi_stream_table #(
    .NUM_RE (NUM_RE),
    .KEY_W  (KEY_W)
  ) u_table (
    .clk              (clk),
    .rst              (rst),
    .i_lookup         (w_lookup),
    .i_key            (r_key),
    .i_cfg_we         (cfg_we),
    .i_cfg_addr       (cfg_addr),
    .i_cfg_enable     (cfg_enable),
    .o_sel_id         (w_sel_id),
    .o_new            (w_new),
    .o_sel_enable     (w_sel_enable),
    .o_streams_active (streams_active),
    .o_evict_cnt      (evict_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_lookup    = 1'b0;
    w_load_key  = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = ~(s_valid & s_sop);
        w_drop    = s_valid & ~s_sop;
        // The sop beat is left on the bus; it is consumed in ST_STREAM.
        if (s_valid && s_sop && (r_cool == 2'd0)) begin
          w_load_key  = 1'b1;
          w_state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        w_lookup    = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD:   w_state_nxt = ST_GAP;
      ST_GAP:    w_state_nxt = ST_STREAM;
      ST_STREAM: begin
        w_s_ready = 1'b1;
        // Only the packet's own sop beat is forwarded; any later sop is dropped.
        w_accept  = s_valid & ~(s_sop & r_sop_taken);
        w_drop    = s_valid & s_sop & r_sop_taken;
        if (w_accept && s_eop) begin
          w_state_nxt = ST_EOP;
        end
      end
      ST_EOP:    w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_stream_id <= '0;
      r_new       <= 1'b0;
      r_enable    <= '0;
      r_char      <= '0;
      r_char_vld  <= 1'b0;
      r_eop       <= 1'b0;
      r_sop_taken <= 1'b0;
      r_cool      <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_char_vld <= w_accept;
      // eop lands in HOLD, one cycle after the final char_in_vld.
      r_eop      <= (r_state == ST_EOP);
      if (w_accept) begin
        r_char <= s_data;
      end
      if (w_load_key) begin
        r_key <= s_key;
      end
      if (w_lookup) begin
        r_stream_id <= w_sel_id;
        r_new       <= w_new;
        r_enable    <= w_sel_enable;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc16(r_drop_cnt);
      end
      if (r_state == ST_HOLD) begin
        r_cool <= COOLDOWN;
      end else if ((r_state == ST_IDLE) && (r_cool != 2'd0)) begin
        r_cool <= r_cool - 2'd1;
      end
      if (r_state == ST_LOOKUP) begin
        r_sop_taken <= 1'b0;
      end else if (w_accept) begin
        r_sop_taken <= 1'b1;
      end
    end
  end

  assign s_ready       = w_s_ready;
  assign char_in       = r_char;
  assign char_in_vld   = r_char_vld;
  assign load_state    = (r_state == ST_LOAD);
  assign new_stream_id = (r_state == ST_LOAD) & r_new;
  assign stream_id     = r_stream_id;
  assign eop           = r_eop;
  assign enable        = r_enable;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
module tb_dpi_stream_feeder;

  localparam int NUM_RE = 8;
  localparam int KEY_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_sop;
  logic              s_eop;
  logic [KEY_W-1:0]  s_key;
  logic              s_ready;
  logic              cfg_we;
  logic [5:0]        cfg_addr;
  logic [NUM_RE-1:0] cfg_enable;
  logic [7:0]        char_in;
  logic              char_in_vld;
  logic              load_state;
  logic              new_stream_id;
  logic [5:0]        stream_id;
  logic              eop;
  logic [NUM_RE-1:0] enable;
  logic [6:0]        streams_active;
  logic [15:0]       evict_cnt;
  logic [15:0]       drop_cnt;

  dpi_stream_feeder #(.NUM_RE(NUM_RE), .KEY_W(KEY_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_sop          (s_sop),
    .s_eop          (s_eop),
    .s_key          (s_key),
    .s_ready        (s_ready),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_enable     (cfg_enable),
    .char_in        (char_in),
    .char_in_vld    (char_in_vld),
    .load_state     (load_state),
    .new_stream_id  (new_stream_id),
    .stream_id      (stream_id),
    .eop            (eop),
    .enable         (enable),
    .streams_active (streams_active),
    .evict_cnt      (evict_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int          n_load, load_cyc, n_chr, first_chr_cyc, last_chr_cyc;
  int          n_eop, eop_cyc, load_gap, excl_bad, en_bad;
  logic        load_new;
  logic [5:0]  load_id;
  logic [7:0]  load_en;
  logic [7:0]  chr_bytes [8];
  logic        in_pkt;
  int          sop_cyc, acc_cyc;

  initial begin
    n_load = 0; load_cyc = 0; n_chr = 0; first_chr_cyc = 0; last_chr_cyc = 0;
    n_eop = 0; eop_cyc = 0; load_gap = 0; excl_bad = 0; en_bad = 0;
    load_new = 1'b0; load_id = '0; load_en = '0; in_pkt = 1'b0;
    sop_cyc = 0; acc_cyc = 0;
  end

  always @(negedge clk) begin
    if (int'(load_state) + int'(eop) + int'(char_in_vld) > 1) excl_bad++;
    if (in_pkt && (enable !== load_en)) en_bad++;
    if (load_state) begin
      n_load++;
      load_cyc = cyc;
      load_new = new_stream_id;
      load_id  = stream_id;
      load_en  = enable;
      load_gap = cyc - eop_cyc;
      in_pkt   = 1'b1;
    end
    if (char_in_vld) begin
      if (n_chr < 8) chr_bytes[n_chr] = char_in;
      if (n_chr == 0) first_chr_cyc = cyc;
      last_chr_cyc = cyc;
      n_chr++;
    end
    if (eop) begin
      n_eop++;
      eop_cyc = cyc;
      in_pkt  = 1'b0;
    end
  end

  task automatic send_pkt(input logic [31:0] key, input int n, input int drain);
    int sent;
    int budget;
    n_load = 0; n_chr = 0; n_eop = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_sop = 1'b1; s_eop = (n == 1); s_key = key; s_data = 8'h10;
    sop_cyc = cyc;
    sent = 0; budget = 0;
    while (sent < n && budget < 100) begin
      @(negedge clk);
      budget++;
      if (s_ready) begin
        acc_cyc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      if (sent > 0) begin
        s_sop  = 1'b0;
        s_data = 8'h10 + 8'(sent);
        s_eop  = (sent == n - 1);
      end
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    if (budget >= 100) chk_eq("send_timeout", 32'(sent), 32'(n));
    repeat (drain) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int budget;
    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_key = '0; s_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_enable = '0;
    repeat (3) @(posedge clk); #1;

    // Reset state
    chk_eq("rst_s_ready",   32'(s_ready), 32'd1);
    chk_eq("rst_load",      32'(load_state), 32'd0);
    chk_eq("rst_char_vld",  32'(char_in_vld), 32'd0);
    chk_eq("rst_eop",       32'(eop), 32'd0);
    chk_eq("rst_active",    32'(streams_active), 32'd0);
    chk_eq("rst_evict",     32'(evict_cnt), 32'd0);
    chk_eq("rst_drop",      32'(drop_cnt), 32'd0);
    chk_eq("rst_stream_id", 32'(stream_id), 32'd0);
    chk_eq("rst_enable",    32'(enable), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // New flow, 3-byte packet
    send_pkt(32'hA5A5_0001, 3, 8);
    chk_eq("new_n_load",    32'(n_load), 32'd1);
    chk_eq("new_new",       32'(load_new), 32'd1);
    chk_eq("new_id",        32'(load_id), 32'd0);
    chk_eq("new_load_lat",  32'(load_cyc - sop_cyc), 32'd2);
    chk_eq("new_chr_lat",   32'(first_chr_cyc - sop_cyc), 32'd5);
    chk_eq("new_n_chr",     32'(n_chr), 32'd3);
    chk_eq("new_b0",        32'(chr_bytes[0]), 32'h10);
    chk_eq("new_b1",        32'(chr_bytes[1]), 32'h11);
    chk_eq("new_b2",        32'(chr_bytes[2]), 32'h12);
    chk_eq("new_eop_lat",   32'(eop_cyc - acc_cyc), 32'd2);
    chk_eq("new_n_eop",     32'(n_eop), 32'd1);
    chk_eq("new_active",    32'(streams_active), 32'd1);
    chk_eq("new_enable",    32'(load_en), 32'hFF);

    // Repeat flow, then a second flow
    send_pkt(32'hA5A5_0001, 1, 8);
    chk_eq("rep_new",    32'(load_new), 32'd0);
    chk_eq("rep_id",     32'(load_id), 32'd0);
    chk_eq("rep_active", 32'(streams_active), 32'd1);
    send_pkt(32'hA5A5_0002, 2, 8);
    chk_eq("sec_new",    32'(load_new), 32'd1);
    chk_eq("sec_id",     32'(load_id), 32'd1);
    chk_eq("sec_active", 32'(streams_active), 32'd2);

    // Fill the table, then evict
    for (int i = 2; i < 64; i++) send_pkt(32'h1000_0000 + 32'(i), 1, 8);
    chk_eq("full_last_id", 32'(load_id), 32'd63);
    chk_eq("full_active",  32'(streams_active), 32'd64);
    chk_eq("full_evict",   32'(evict_cnt), 32'd0);
    send_pkt(32'h2000_0000, 1, 8);
    chk_eq("ev1_id",     32'(load_id), 32'd0);
    chk_eq("ev1_new",    32'(load_new), 32'd1);
    chk_eq("ev1_evict",  32'(evict_cnt), 32'd1);
    chk_eq("ev1_active", 32'(streams_active), 32'd64);
    send_pkt(32'h2000_0001, 1, 8);
    chk_eq("ev2_id",     32'(load_id), 32'd1);
    chk_eq("ev2_new",    32'(load_new), 32'd1);
    chk_eq("ev2_evict",  32'(evict_cnt), 32'd2);

    // Enable config on stream 0
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_enable = 8'h05;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    en_bad = 0;
    send_pkt(32'h2000_0000, 2, 8);
    chk_eq("cfg_id",     32'(load_id), 32'd0);
    chk_eq("cfg_new",    32'(load_new), 32'd0);
    chk_eq("cfg_enable", 32'(load_en), 32'h05);
    chk_eq("cfg_hold",   32'(en_bad), 32'd0);
    send_pkt(32'h2000_0001, 1, 8);
    chk_eq("cfg_other_en", 32'(load_en), 32'hFF);

    // Stray non-sop beat in IDLE, then a single-byte packet
    chk_eq("drop_before", 32'(drop_cnt), 32'd0);
    n_chr = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_sop = 1'b0; s_data = 8'hEE;
    @(negedge clk);
    chk_eq("drop_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk_eq("drop_cnt",  32'(drop_cnt), 32'd1);
    chk_eq("drop_nchr", 32'(n_chr), 32'd0);
    send_pkt(32'h2000_0001, 1, 8);
    chk_eq("one_n_chr",  32'(n_chr), 32'd1);
    chk_eq("one_byte",   32'(chr_bytes[0]), 32'h10);
    chk_eq("one_n_eop",  32'(n_eop), 32'd1);
    chk_eq("one_eop_at", 32'(eop_cyc - first_chr_cyc), 32'd1);

    // Back-to-back packets: four quiet cycles between eop and next load
    send_pkt(32'h2000_0000, 2, 0);
    send_pkt(32'h2000_0001, 1, 8);
    chk_eq("b2b_gap", 32'(load_gap), 32'd5);
    chk_eq("b2b_id",  32'(load_id), 32'd1);

    // Reset in the middle of a packet
    n_eop = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_key = 32'h3000_0000; s_data = 8'h40;
    sent = 0; budget = 0;
    while (sent < 2 && budget < 50) begin
      @(negedge clk);
      budget++;
      if (s_ready) sent++;
      @(posedge clk); #1;
      if (sent > 0) begin
        s_sop  = 1'b0;
        s_data = 8'h41;
      end
    end
    chk_eq("mid_accepts", 32'(sent), 32'd2);
    #2;
    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; in_pkt = 1'b0;
    #1;
    chk_eq("mid_rst_active", 32'(streams_active), 32'd0);
    chk_eq("mid_rst_vld",    32'(char_in_vld), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    chk_eq("mid_no_eop", 32'(n_eop), 32'd0);
    send_pkt(32'h2000_0000, 1, 8);
    chk_eq("mid_after_new", 32'(load_new), 32'd1);
    chk_eq("mid_after_id",  32'(load_id), 32'd0);

    chk_eq("mutex",   32'(excl_bad), 32'd0);
    chk_eq("en_hold", 32'(en_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
